dm_ext: RTL
===========

Name: dm_ext

Overview:
- Parametrised data memory for the pipelined MIPS core; replaces the word-only DM in the MEM stage.
- Adds byte/halfword/word stores with byte merging, and sign/zero-extended sub-word loads.
- Adds alignment and range exception flags and a multi-cycle clear sequence with a busy output.
- Keeps the grader-format write trace so existing testbench comparison still works.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words; legal byte addresses are 0 .. 4*DEPTH_WORDS-1.
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.
- CLEAR_PER_CYCLE, 4, words zeroed per cycle during the clear sweep; must divide DEPTH_WORDS.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- MemWrite  in  1  store request, valid this cycle.
- MemRead  in  1  load request; used only for exception flagging.
- StoreMode  in  2  encodes SW, SH or SB.
- LoadMode  in  3  encodes LW, LH, LHU, LB or LBU.
- pc  in  32  PC of the instruction in MEM; used only for the trace.
- Addr  in  32  byte address.
- WriteData  in  32  rt value; the sub-word is taken from its low bits.
- RD  out  32  extended load result, combinational.
- busy  out  1  clear sweep in progress.
- AdEL  out  1  load is misaligned or out of range.
- AdES  out  1  store is misaligned or out of range.

Behaviour:
- Word index = (Addr-BASE_ADDR)>>2. Byte offset = Addr[1:0].
- In range means BASE_ADDR <= Addr < BASE_ADDR + 4*DEPTH_WORDS.
- Alignment rules:
  - SW/LW require offset 0.
  - SH/LH/LHU require Addr[0]=0.
  - Byte accesses are always aligned.
- Flags are combinational:
  - AdES = MemWrite & (misaligned | out of range).
  - AdEL = MemRead & (misaligned | out of range).
  - Both are forced to 0 while busy.
- Store commits on the rising edge only when MemWrite & !AdES & !busy.
  - Byte enables: SW -> 4'b1111; SH -> 4'b0011 << offset; SB -> 4'b0001 << offset.
  - Lane data: SW -> WriteData; SH -> {2{WriteData[15:0]}}; SB -> {4{WriteData[7:0]}}.
  - Only enabled bytes change. Other bytes of the word are preserved.
- Trace: every committed store prints "@%h: *%h <= %h" with pc, word-aligned byte address, and the full merged word after the write.
- Load is combinational from the current array contents. There is no store-to-load forwarding inside the same cycle; the old value is returned.
  - LW: the whole word.
  - LH/LHU: the halfword at Addr[1] (0 = bits [15:0]), sign- or zero-extended.
  - LB/LBU: the byte at the offset (0 = bits [7:0]), extended the same way.
  - Out of range, misaligned, or busy: RD = 0.
- FSM states:
  - IDLE: normal operation.
  - CLEAR: a sweep counter clr_idx zeroes CLEAR_PER_CYCLE consecutive words per cycle.
- FSM transitions:
  - reset=1 in any state -> CLEAR, clr_idx <= 0, busy <= 1 on the next cycle. This restarts the sweep if reset arrives mid-sweep.
  - CLEAR with reset=0 -> clr_idx += CLEAR_PER_CYCLE.
  - When the last group is zeroed -> IDLE, busy <= 0.
- Sweep timing: from the cycle reset deasserts, busy stays high for exactly DEPTH_WORDS/CLEAR_PER_CYCLE cycles (768 at defaults). While reset is held, clr_idx is pinned at 0 and the first group is zeroed every cycle.
- Reset values: state=CLEAR, clr_idx=0, busy=1. RD, AdEL and AdES read 0 while busy.
- While busy, stores are dropped with no trace. The core must stall MEM on busy.
- Simultaneous store and load to the same address: the load returns the pre-store data; the store commits at the edge.

Decomposition:
- Package dm_pkg holds:
  - StoreMode constants: ST_W=2'd0, ST_H=2'd1, ST_B=2'd2 (2'd3 is reserved and treated as no store).
  - LoadMode constants: LD_W=0, LD_H=1, LD_HU=2, LD_B=3, LD_BU=4 (others return 0).
  - FSM state enum.
- One natural sub-module, dm_load_ext: purely combinational. It takes the word, offset and LoadMode and produces the extended 32-bit RD. The same block is reusable in the forwarding path.

Test Plan:
- Reset held 3 cycles, then released -> busy=1 for exactly 768 cycles, then 0. Any word (e.g. 0x0, 0x2FFC) then reads 0.
- Store then byte loads: SW 0x8765_4321 @0x10, then SB 0xAA @0x13 -> trace "*00000010 <= aa654321". LB @0x13 -> 0xFFFF_FFAA. LBU @0x13 -> 0x0000_00AA.
- SH 0x0000_BEEF @0x22 on a zeroed word -> word becomes 0xBEEF_0000. LH @0x22 -> 0xFFFF_BEEF. LHU -> 0x0000_BEEF.
- Misalignment: SW @0x6 -> AdES=1, memory unchanged, no trace. LH @0x5 -> AdEL=1, RD=0.
- Range: SW @0x3000 -> AdES=1. LW @0x2FFC -> AdEL=0 and returns stored data.
- Mid-sweep reset: pulse reset at sweep cycle 100 -> the sweep restarts, busy stays high for 768 cycles after release. A store attempted during busy leaves memory at 0.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared encodings for the extended data memory: access modes, FSM states and
// alignment helpers used by both the top and the load extender.
package dm_pkg;

  // StoreMode encodings; ST_RSVD performs no store.
  localparam logic [1:0] ST_W    = 2'd0;
  localparam logic [1:0] ST_H    = 2'd1;
  localparam logic [1:0] ST_B    = 2'd2;
  localparam logic [1:0] ST_RSVD = 2'd3;

  // LoadMode encodings; any other value returns zero.
  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_H  = 3'd1;
  localparam logic [2:0] LD_HU = 3'd2;
  localparam logic [2:0] LD_B  = 3'd3;
  localparam logic [2:0] LD_BU = 3'd4;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } dm_state_e;

  // Word accesses need offset 0, halfword accesses need an even address.
  function automatic logic st_misaligned(logic [1:0] mode, logic [1:0] off);
    case (mode)
      ST_W:    return off != 2'd0;
      ST_H:    return off[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic ld_misaligned(logic [2:0] mode, logic [1:0] off);
    case (mode)
      LD_W:        return off != 2'd0;
      LD_H, LD_HU: return off[0];
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Combinational sub-word selector and sign/zero extender for loads.
// Shared between the memory read port and the core's forwarding path.
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_mode,
  output logic [31:0] o_rd
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  // Pick the addressed lane and extend it according to the load mode.
  always_comb begin
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
    w_byte = i_word[{i_off, 3'b000} +: 8];
    o_rd   = '0;
    case (i_mode)
      LD_W:    o_rd = i_word;
      LD_H:    o_rd = {{16{w_half[15]}}, w_half};
      LD_HU:   o_rd = {16'b0, w_half};
      LD_B:    o_rd = {{24{w_byte[7]}}, w_byte};
      LD_BU:   o_rd = {24'b0, w_byte};
      default: o_rd = '0;
    endcase
  end

endmodule

// File: rtl/dm_ext.sv
// Data memory for the MEM stage: byte/halfword/word stores with byte merging,
// extended sub-word loads, address exception flags and a post-reset clear sweep.
module dm_ext
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS     = 3072,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned CLEAR_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  StoreMode,
  input  logic [2:0]  LoadMode,
  input  logic [31:0] pc,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] RD,
  output logic        busy,
  output logic        AdEL,
  output logic        AdES
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] MemBytes = 32'(4 * DEPTH_WORDS);
  localparam logic [AW-1:0] LastIdx = AW'(DEPTH_WORDS - CLEAR_PER_CYCLE);
  localparam logic [AW-1:0] ClrStep = AW'(CLEAR_PER_CYCLE);

  logic [31:0]   r_mem [DEPTH_WORDS];
  dm_state_e     r_state;
  logic [AW-1:0] r_clr_idx;
  logic          r_busy;

  logic [31:0]   w_rel;
  logic          w_in_range;
  logic          w_st_mis;
  logic          w_ld_mis;
  logic          w_ades;
  logic          w_adel;
  logic          w_commit;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [3:0]    w_be;
  logic [31:0]   w_lane;
  logic [31:0]   w_merged;
  logic [31:0]   w_ext;

  assign w_rel      = Addr - BASE_ADDR;
  assign w_in_range = (Addr >= BASE_ADDR) && (w_rel < MemBytes);
  assign w_st_mis   = st_misaligned(StoreMode, Addr[1:0]);
  assign w_ld_mis   = ld_misaligned(LoadMode, Addr[1:0]);

  // Out-of-range addresses are steered to word 0 so the read never leaves the array.
  assign w_idx  = w_in_range ? w_rel[AW+1:2] : '0;
  assign w_word = r_mem[w_idx];

  assign w_ades   = MemWrite & ~r_busy & (w_st_mis | ~w_in_range);
  assign w_adel   = MemRead & ~r_busy & (w_ld_mis | ~w_in_range);
  assign w_commit = MemWrite & ~w_ades & ~r_busy & (StoreMode != ST_RSVD);

  assign AdES = w_ades;
  assign AdEL = w_adel;
  assign busy = r_busy;

  // Byte enables and replicated lane data for the store.
  always_comb begin
    w_be   = '0;
    w_lane = '0;
    case (StoreMode)
      ST_W: begin
        w_be   = 4'b1111;
        w_lane = WriteData;
      end
      ST_H: begin
        w_be   = 4'b0011 << Addr[1:0];
        w_lane = {2{WriteData[15:0]}};
      end
      ST_B: begin
        w_be   = 4'b0001 << Addr[1:0];
        w_lane = {4{WriteData[7:0]}};
      end
      default: ;
    endcase
  end

  // Word as it will look after the store; only used by the trace.
  always_comb begin
    w_merged = w_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (w_be[b]) w_merged[8*b +: 8] = w_lane[8*b +: 8];
    end
  end

  dm_load_ext u_load_ext (
    .i_word (w_word),
    .i_off  (Addr[1:0]),
    .i_mode (LoadMode),
    .o_rd   (w_ext)
  );

  assign RD = (r_busy | ~w_in_range | w_ld_mis) ? 32'h0 : w_ext;

  // Clear-sweep FSM: reset (re)starts the sweep at group 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StClear;
      r_clr_idx <= '0;
      r_busy    <= 1'b1;
    end else begin
      unique case (r_state)
        StClear: begin
          if (r_clr_idx == LastIdx) begin
            r_state   <= StIdle;
            r_clr_idx <= '0;
            r_busy    <= 1'b0;
          end else begin
            r_clr_idx <= r_clr_idx + ClrStep;
          end
        end
        StIdle: ;
        default: r_state <= StClear;
      endcase
    end
  end

  // Array update: zero the current group while sweeping, else merge enabled store bytes.
  always_ff @(posedge clk) begin
    if (r_state == StClear) begin
      for (int unsigned k = 0; k < CLEAR_PER_CYCLE; k++) begin
        r_mem[r_clr_idx + AW'(k)] <= '0;
      end
    end else if (w_commit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_lane[8*b +: 8];
      end
    end
  end

`ifndef SYNTHESIS
  // Write trace in the grader format: pc, word-aligned address, merged word.
  always @(posedge clk) begin
    if (w_commit) $display("@%h: *%h <= %h", pc, {Addr[31:2], 2'b00}, w_merged);
  end
`endif

endmodule
